// File: rtl/johnson_ctrl_pkg.sv
// Shared types for the Johnson step controller: command opcodes and FSM states.
package johnson_ctrl_pkg;

   typedef enum logic [1:0] {
      OP_STOP = 2'b00,
      OP_RUN  = 2'b01,
      OP_STEP = 2'b10,
      OP_LOAD = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'b00,
      ST_RUN       = 2'b01,
      ST_STEP_WAIT = 2'b10
   } state_e;

endpackage

// File: rtl/prescale_down.sv
// Programmable prescaler: divisor register plus a down-counter that flags a
// terminal count every DIV_R+1 enabled cycles.
module prescale_down #(
   parameter int DIV_W = 22
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,        // count this cycle (controller not idle)
   input  logic             start,     // restart the period from the held divisor
   input  logic             load_div,  // capture a new divisor
   input  logic             load_cnt,  // restart the period from the new divisor
   input  logic [DIV_W-1:0] div_in,
   output logic             tc
);

   localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

   logic [DIV_W-1:0] div_r;
   logic [DIV_W-1:0] cnt;

   assign tc = en && (cnt == '0);

   // Divisor capture and counter reload/decrement; a fresh divisor load wins
   // over the terminal-count reload so the new period starts at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_r <= '1;
         cnt   <= '1;
      end else begin
         if (load_div)
            div_r <= div_in;
         if (load_cnt)
            cnt <= div_in;
         else if (start)
            cnt <= div_r;
         else if (en)
            cnt <= tc ? div_r : cnt - ONE;
      end
   end

endmodule

// File: rtl/johnson_step_ctrl.sv
// Johnson counter driven by a command-controlled prescaler: free-run, single
// step, stop and divisor load, with per-shift direction control.
module johnson_step_ctrl
   import johnson_ctrl_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int DIV_W = 22
) (
   input  logic             CLK,
   input  logic             RESETN,
   input  logic             CMD_VALID,
   output logic             CMD_READY,
   input  logic [1:0]       CMD_OP,
   input  logic [DIV_W-1:0] CMD_DIV,
   input  logic             DIR,
   output logic [WIDTH-1:0] O,
   output logic             TICK,
   output logic             BUSY
);

   state_e state;
   op_e    op;
   logic   accept;
   logic   tc;
   logic   start;
   logic   load_div;
   logic   load_cnt;

   assign op        = op_e'(CMD_OP);
   assign CMD_READY = (state != ST_STEP_WAIT);
   assign BUSY      = (state != ST_IDLE);
   assign accept    = CMD_VALID && CMD_READY;

   // RUN/STEP only (re)start the period from idle; LOAD while running also
   // restarts it so the new rate applies immediately.
   assign start    = accept && (state == ST_IDLE) && ((op == OP_RUN) || (op == OP_STEP));
   assign load_div = accept && (op == OP_LOAD);
   assign load_cnt = load_div && (state == ST_RUN);

   prescale_down #(.DIV_W(DIV_W)) u_prescale (
      .clk      (CLK),
      .rst_n    (RESETN),
      .en       (BUSY),
      .start    (start),
      .load_div (load_div),
      .load_cnt (load_cnt),
      .div_in   (CMD_DIV),
      .tc       (tc)
   );

   // Control FSM and Johnson register; a terminal count always shifts, even
   // on the edge that stops the counter.
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state <= ST_IDLE;
         O     <= '0;
         TICK  <= 1'b0;
      end else begin
         TICK <= tc;
         if (tc)
            O <= DIR ? {~O[0], O[WIDTH-1:1]} : {O[WIDTH-2:0], ~O[WIDTH-1]};
         case (state)
            ST_IDLE: begin
               if (accept && (op == OP_RUN))
                  state <= ST_RUN;
               else if (accept && (op == OP_STEP))
                  state <= ST_STEP_WAIT;
            end
            ST_RUN: begin
               if (accept && (op == OP_STOP))
                  state <= ST_IDLE;
            end
            ST_STEP_WAIT: begin
               if (tc)
                  state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
